controle_fechadura: RTL and testbench
=====================================

# controle_fechadura

Lock-control state machine sitting downstream of `comparador_6bits`. It consumes the comparator's one-cycle `senha_correta`/`senha_errada` pulses and drives the open/lockout outputs. It also owns the stored password: it holds the register that feeds the comparator's `B` input, and rewrites that register on a save request while the lock is open.

## Interface
Parameters:
- `MAX_TENTATIVAS`, 3: consecutive wrong attempts that trigger lockout; legal range 1..3.
- `T_ABERTO`, 250_000_000: cycles the lock stays open (5 s at 50 MHz); must be ≥ 2.
- `T_BLOQUEIO`, 1_500_000_000: lockout duration in cycles (30 s at 50 MHz); must be ≥ 2.
- `SENHA_INICIAL`, 6'b101010: stored password after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `senha_correta` in 1: one-cycle pulse from the comparator.
- `senha_errada` in 1: one-cycle pulse from the comparator.
- `salvar_btn` in 1: level input; its rising edge is the save request.
- `senha_nova` in 6: candidate new password, sampled on the save edge.
- `senha_atual` out 6: stored password, wired to the comparator's `B` input.
- `aberto` out 1: high while in ABERTO.
- `bloqueado` out 1: high while in BLOQUEADO.
- `tentativas` out 2: current count of consecutive wrong attempts.

## Operation
- Reset values:
  - state TRANCADO
  - `aberto`=0, `bloqueado`=0, `tentativas`=0
  - `senha_atual`=`SENHA_INICIAL`
  - timer 0, save edge register 0
- The save edge register samples `salvar_btn` every cycle in every state. A button held across a state change therefore never produces a spurious edge.
- TRANCADO:
  - `senha_correta` → ABERTO; timer ← `T_ABERTO`-1; `tentativas` ← 0.
  - `senha_errada`, with `tentativas`+1 < `MAX_TENTATIVAS` → `tentativas` increments; stay in TRANCADO.
  - `senha_errada`, with `tentativas`+1 = `MAX_TENTATIVAS` → BLOQUEADO; timer ← `T_BLOQUEIO`-1; `tentativas` ← `MAX_TENTATIVAS` (held there).
  - Save edges are ignored.
- ABERTO:
  - Comparator pulses are ignored.
  - Save edge → `senha_atual` ← `senha_nova`, and the timer reloads to `T_ABERTO`-1 (the open window restarts).
  - Timer = 0 → TRANCADO.
- BLOQUEADO:
  - Comparator pulses and save edges are ignored.
  - Timer = 0 → TRANCADO; `tentativas` ← 0.
- Both pulses in the same cycle (protocol violation) are treated as `senha_errada` (fail-safe).
- The timer decrements by 1 per cycle in ABERTO and BLOQUEADO and saturates at 0. It is 31 bits wide, enough for `T_BLOQUEIO`.
- `tentativas` never wraps; it is bounded by `MAX_TENTATIVAS`.
- `rst` asserted mid-operation (open, locked out, or mid-save) returns every output to its reset value on the next edge. A password saved before the reset is lost.

## Timing
- All outputs are registered (Moore).
- A pulse at edge n changes state and outputs at edge n+1.
- `aberto` stays high for exactly `T_ABERTO` cycles, or `T_ABERTO` cycles counted from the last save edge.
- `bloqueado` stays high for exactly `T_BLOQUEIO` cycles.
- Save edge: `salvar_btn` goes 0→1 and is seen at edge n; the edge is detected at n+1; `senha_atual` updates at n+2. The comparator uses the new value from its next ENTER onward.
- A pulse arriving in the same cycle that ABERTO or BLOQUEADO expires is ignored; the lock returns to TRANCADO first.

## Structure
- `fechadura_pkg` holds:
  - the state encoding: TRANCADO=2'd0, ABERTO=2'd1, BLOQUEADO=2'd2 (2'd3 unreachable; recovers to TRANCADO)
  - the timer width constant: 31
  - the default `SENHA_INICIAL`
- One sub-module, `temporizador_descendente`:
  - inputs: load, value, enable
  - behaviour: down-counter saturating at 0
  - output: `zero` flag
- The FSM, attempt counter, password register and edge detector live in the top module.

## Test plan
Bench parameters: `T_ABERTO`=4, `T_BLOQUEIO`=8, `MAX_TENTATIVAS`=3.
- Reset → `senha_atual`=101010, `aberto`=0, `bloqueado`=0, `tentativas`=0.
- `senha_correta` pulse at edge 10 → `aberto`=1 on edges 11–14, 0 at edge 15; `tentativas`=0.
- Three `senha_errada` pulses → `tentativas` goes 1, 2; third pulse → `bloqueado`=1 for 8 cycles, then 0 and `tentativas`=0. A `senha_correta` pulse during lockout has no effect.
- In ABERTO, `senha_nova`=6'b001100 with a `salvar_btn` rise → `senha_atual`=001100 two edges later; `aberto` stays high for 4 cycles from the save. `salvar_btn` held high across entry to ABERTO causes no update.
- Both pulses in the same cycle in TRANCADO → `tentativas` increments; `aberto` stays 0.
- `rst` asserted during BLOQUEADO and during ABERTO after a save → next edge: TRANCADO, `senha_atual`=101010, `bloqueado`=0, `aberto`=0.

Source files
------------

// File: rtl/fechadura_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fechadura_pkg
//  Description : Shared state encoding, timer width and default password
//                for the lock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fechadura_pkg;

    localparam int          c_TIMER_W           = 31;
    localparam logic [5:0]  c_SENHA_INICIAL_DEF = 6'b101010;

    localparam logic [1:0]  c_ST_TRANCADO  = 2'd0;
    localparam logic [1:0]  c_ST_ABERTO    = 2'd1;
    localparam logic [1:0]  c_ST_BLOQUEADO = 2'd2;

endpackage : fechadura_pkg
`default_nettype wire

// File: rtl/controle_fechadura_temporizador.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_descendente
//  Description : Loadable down-counter that saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporizador_descendente
    import fechadura_pkg::*;
#(
    parameter int WIDTH = c_TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : temporizador_descendente
`default_nettype wire

// File: rtl/controle_fechadura.sv
`default_nettype none
// ============================================================================
//  Module      : controle_fechadura
//  Description : Lock controller: open/lockout FSM, wrong-attempt counter,
//                stored password register and save-button edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_fechadura
    import fechadura_pkg::*;
#(
    parameter int                   MAX_TENTATIVAS = 3,
    parameter logic [c_TIMER_W-1:0] T_ABERTO       = 31'd250_000_000,
    parameter logic [c_TIMER_W-1:0] T_BLOQUEIO     = 31'd1_500_000_000,
    parameter logic [5:0]           SENHA_INICIAL  = c_SENHA_INICIAL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       senha_correta,
    input  logic       senha_errada,
    input  logic       salvar_btn,
    input  logic [5:0] senha_nova,
    output logic [5:0] senha_atual,
    output logic       aberto,
    output logic       bloqueado,
    output logic [1:0] tentativas
);

    localparam logic [c_TIMER_W-1:0] c_T_ABERTO_M1   = T_ABERTO - 31'd1;
    localparam logic [c_TIMER_W-1:0] c_T_BLOQUEIO_M1 = T_BLOQUEIO - 31'd1;
    localparam logic [1:0]           c_MAX_TENT      = 2'(MAX_TENTATIVAS);

    logic [1:0]           r_state;
    logic [1:0]           r_tentativas;
    logic [5:0]           r_senha;
    logic                 r_aberto;
    logic                 r_bloqueado;
    logic                 r_btn_d1;
    logic                 r_btn_d2;
    logic                 r_save_pulse;
    logic [5:0]           r_senha_capt;

    logic                 w_last_try;
    logic                 w_tmr_load;
    logic [c_TIMER_W-1:0] w_tmr_value;
    logic                 w_tmr_enable;
    logic                 w_tmr_zero;

    assign w_last_try   = (({1'b0, r_tentativas} + 3'd1) == {1'b0, c_MAX_TENT});
    assign w_tmr_enable = (r_state == c_ST_ABERTO) || (r_state == c_ST_BLOQUEADO);

    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = c_T_ABERTO_M1;
        case (r_state)
            c_ST_TRANCADO: begin
                // errada wins when both pulses arrive together
                if (senha_errada) begin
                    if (w_last_try) begin
                        w_tmr_load  = 1'b1;
                        w_tmr_value = c_T_BLOQUEIO_M1;
                    end
                end else if (senha_correta) begin
                    w_tmr_load = 1'b1;
                end
            end
            c_ST_ABERTO: begin
                if (!w_tmr_zero && r_save_pulse) begin
                    w_tmr_load = 1'b1;
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    temporizador_descendente #(
        .WIDTH  (c_TIMER_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_tmr_load),
        .value  (w_tmr_value),
        .enable (w_tmr_enable),
        .zero   (w_tmr_zero)
    );

    // Two-stage edge detect; sampled in every state so a held button is inert
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_d1     <= 1'b0;
            r_btn_d2     <= 1'b0;
            r_save_pulse <= 1'b0;
            r_senha_capt <= '0;
        end else begin
            r_btn_d1     <= salvar_btn;
            r_btn_d2     <= r_btn_d1;
            r_save_pulse <= r_btn_d1 & ~r_btn_d2;
            if (r_btn_d1 & ~r_btn_d2) begin
                r_senha_capt <= senha_nova;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_TRANCADO;
            r_tentativas <= 2'd0;
            r_senha      <= SENHA_INICIAL;
            r_aberto     <= 1'b0;
            r_bloqueado  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_TRANCADO: begin
                    if (senha_errada) begin
                        if (w_last_try) begin
                            r_state      <= c_ST_BLOQUEADO;
                            r_tentativas <= c_MAX_TENT;
                            r_bloqueado  <= 1'b1;
                        end else begin
                            r_tentativas <= r_tentativas + 2'd1;
                        end
                    end else if (senha_correta) begin
                        r_state      <= c_ST_ABERTO;
                        r_tentativas <= 2'd0;
                        r_aberto     <= 1'b1;
                    end
                end
                c_ST_ABERTO: begin
                    if (w_tmr_zero) begin
                        r_state  <= c_ST_TRANCADO;
                        r_aberto <= 1'b0;
                    end else if (r_save_pulse) begin
                        r_senha <= r_senha_capt;
                    end
                end
                c_ST_BLOQUEADO: begin
                    if (w_tmr_zero) begin
                        r_state      <= c_ST_TRANCADO;
                        r_tentativas <= 2'd0;
                        r_bloqueado  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_ST_TRANCADO;
                    r_aberto    <= 1'b0;
                    r_bloqueado <= 1'b0;
                end
            endcase
        end
    end

    assign senha_atual = r_senha;
    assign aberto      = r_aberto;
    assign bloqueado   = r_bloqueado;
    assign tentativas  = r_tentativas;

endmodule : controle_fechadura
`default_nettype wire

// File: tb/tb_controle_fechadura.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_fechadura
//  Description : Directed scoreboard bench for the lock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_fechadura;

    localparam logic [5:0] c_S0 = 6'b101010;
    localparam logic [5:0] c_S1 = 6'b001100;
    localparam logic [5:0] c_S2 = 6'b110011;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       senha_correta;
    logic       senha_errada;
    logic       salvar_btn;
    logic [5:0] senha_nova;
    logic [5:0] senha_atual;
    logic       aberto;
    logic       bloqueado;
    logic [1:0] tentativas;

    sb_entry_t  sb_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;

    controle_fechadura #(
        .MAX_TENTATIVAS (3),
        .T_ABERTO       (31'd4),
        .T_BLOQUEIO     (31'd8),
        .SENHA_INICIAL  (6'b101010)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .senha_correta (senha_correta),
        .senha_errada  (senha_errada),
        .salvar_btn    (salvar_btn),
        .senha_nova    (senha_nova),
        .senha_atual   (senha_atual),
        .aberto        (aberto),
        .bloqueado     (bloqueado),
        .tentativas    (tentativas)
    );

    always #5 clk = ~clk;

    // Push the outputs expected after the next edge, advance, then score
    task automatic cyc(input string tag, input logic ab, input logic bl,
                       input logic [1:0] te, input logic [5:0] se);
        sb_entry_t e;
        logic [9:0] obs;
        e.tag = tag;
        e.exp = {ab, bl, te, se};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        obs = {aberto, bloqueado, tentativas, senha_atual};
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed ab/bl/te/se=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; senha_correta = 1'b0; senha_errada = 1'b0;
        salvar_btn = 1'b0; senha_nova = 6'd0;
        cyc("reset", 0, 0, 2'd0, c_S0);
        rst = 1'b0;
        cyc("idle", 0, 0, 2'd0, c_S0);
        cyc("idle", 0, 0, 2'd0, c_S0);

        // Open for exactly four cycles; wrong pulse while open is ignored
        senha_correta = 1'b1;
        cyc("open_enter", 1, 0, 2'd0, c_S0);
        senha_correta = 1'b0;
        for (int i = 0; i < 3; i++) begin
            senha_errada = (i == 1);
            cyc("open_hold", 1, 0, 2'd0, c_S0);
        end
        senha_errada = 1'b0;
        cyc("open_expire", 0, 0, 2'd0, c_S0);

        // Three wrong attempts lead to an eight-cycle lockout
        senha_errada = 1'b1;
        cyc("err1", 0, 0, 2'd1, c_S0);
        senha_errada = 1'b0;
        cyc("err1_hold", 0, 0, 2'd1, c_S0);
        senha_errada = 1'b1;
        cyc("err2", 0, 0, 2'd2, c_S0);
        cyc("lock_enter", 0, 1, 2'd3, c_S0);
        senha_errada = 1'b0;
        for (int i = 0; i < 7; i++) begin
            senha_correta = (i == 2);
            cyc("lock_hold", 0, 1, 2'd3, c_S0);
        end
        // Pulse coinciding with expiry is dropped
        senha_correta = 1'b1;
        cyc("lock_expire", 0, 0, 2'd0, c_S0);
        senha_correta = 1'b0;
        cyc("after_lock", 0, 0, 2'd0, c_S0);

        // Button held high across entry to the open state: no update
        salvar_btn = 1'b1; senha_nova = c_S1;
        for (int i = 0; i < 3; i++) cyc("save_locked", 0, 0, 2'd0, c_S0);
        senha_correta = 1'b1;
        cyc("open2_enter", 1, 0, 2'd0, c_S0);
        senha_correta = 1'b0;
        for (int i = 0; i < 3; i++) cyc("held_btn", 1, 0, 2'd0, c_S0);
        salvar_btn = 1'b0;
        cyc("open2_expire", 0, 0, 2'd0, c_S0);

        // Save rise while open: update two edges later, window restarts
        senha_correta = 1'b1;
        cyc("open3_enter", 1, 0, 2'd0, c_S0);
        senha_correta = 1'b0;
        salvar_btn = 1'b1;
        cyc("save_seen", 1, 0, 2'd0, c_S0);
        cyc("save_detect", 1, 0, 2'd0, c_S0);
        cyc("save_apply", 1, 0, 2'd0, c_S1);
        salvar_btn = 1'b0;
        for (int i = 0; i < 3; i++) cyc("save_hold", 1, 0, 2'd0, c_S1);
        cyc("save_expire", 0, 0, 2'd0, c_S1);

        // Simultaneous pulses count as a wrong attempt
        senha_correta = 1'b1; senha_errada = 1'b1;
        cyc("both_pulses", 0, 0, 2'd1, c_S1);
        senha_correta = 1'b0;
        cyc("err_b2", 0, 0, 2'd2, c_S1);
        cyc("lock2_enter", 0, 1, 2'd3, c_S1);
        senha_errada = 1'b0;
        cyc("lock2_hold", 0, 1, 2'd3, c_S1);
        rst = 1'b1;
        cyc("rst_in_lock", 0, 0, 2'd0, c_S0);
        rst = 1'b0;

        // Reset while open after a save discards the new password
        senha_correta = 1'b1;
        cyc("open4_enter", 1, 0, 2'd0, c_S0);
        senha_correta = 1'b0;
        salvar_btn = 1'b1; senha_nova = c_S2;
        cyc("save2_seen", 1, 0, 2'd0, c_S0);
        cyc("save2_detect", 1, 0, 2'd0, c_S0);
        cyc("save2_apply", 1, 0, 2'd0, c_S2);
        salvar_btn = 1'b0;
        rst = 1'b1;
        cyc("rst_in_open", 0, 0, 2'd0, c_S0);
        rst = 1'b0;
        cyc("final_idle", 0, 0, 2'd0, c_S0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_controle_fechadura
`default_nettype wire
